// File: rtl/bp_be_exception_encoder.sv
// Priority-encodes a RISC-V exception vector into mcause/epc/tval records
// and buffers them in a 2-entry FIFO, counting enqueued traps.
module bp_be_exception_encoder #(
  parameter int eaddr_width_p = 64,
  parameter int count_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [15:0]              exc_i,
  input  logic [eaddr_width_p-1:0] epc_i,
  input  logic [eaddr_width_p-1:0] tval_i,
  input  logic                     flush_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [3:0]               cause_o,
  output logic [eaddr_width_p-1:0] epc_o,
  output logic [eaddr_width_p-1:0] tval_o,
  output logic [count_width_p-1:0] count_o
);

  localparam logic [15:0] valid_mask = 16'hBBFF;
  localparam logic [count_width_p-1:0] count_one =
    {{(count_width_p-1){1'b0}}, 1'b1};

  logic [15:0]              valid;
  logic                     any;
  logic [3:0]               cause_enc;
  logic                     ecall;
  logic [eaddr_width_p-1:0] tval_sel;

  logic [3:0]               cause_mem [2];
  logic [eaddr_width_p-1:0] epc_mem   [2];
  logic [eaddr_width_p-1:0] tval_mem  [2];

  logic                     wptr;
  logic                     rptr;
  logic [1:0]               occ;
  logic [1:0]               occ_n;
  logic                     ready_r;
  logic [count_width_p-1:0] count_r;
  logic                     enq;
  logic                     deq;

  assign valid = exc_i & valid_mask;
  assign any   = |valid;

  always_comb begin
    cause_enc = 4'd0;
    priority case (1'b1)
      valid[12]: cause_enc = 4'd12;
      valid[1]:  cause_enc = 4'd1;
      valid[2]:  cause_enc = 4'd2;
      valid[0]:  cause_enc = 4'd0;
      valid[8]:  cause_enc = 4'd8;
      valid[9]:  cause_enc = 4'd9;
      valid[11]: cause_enc = 4'd11;
      valid[3]:  cause_enc = 4'd3;
      valid[6]:  cause_enc = 4'd6;
      valid[4]:  cause_enc = 4'd4;
      valid[15]: cause_enc = 4'd15;
      valid[13]: cause_enc = 4'd13;
      valid[7]:  cause_enc = 4'd7;
      valid[5]:  cause_enc = 4'd5;
      default:   cause_enc = 4'd0;
    endcase
  end

  // ecalls carry no trap value
  assign ecall = (cause_enc == 4'd8) || (cause_enc == 4'd9)
              || (cause_enc == 4'd11);
  assign tval_sel = ecall ? '0 : tval_i;

  assign v_o     = (occ != 2'd0);
  assign ready_o = ready_r;
  assign count_o = count_r;
  assign enq     = v_i & ready_r & ~flush_i & any;
  assign deq     = yumi_i & v_o & ~flush_i;

  always_comb begin
    occ_n = occ;
    if (flush_i) begin
      occ_n = 2'd0;
    end else if (enq && !deq) begin
      occ_n = occ + 2'd1;
    end else if (deq && !enq) begin
      occ_n = occ - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ     <= 2'd0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      ready_r <= 1'b0;
      count_r <= '0;
    end else begin
      occ     <= occ_n;
      ready_r <= (occ_n < 2'd2);
      if (flush_i) begin
        wptr <= 1'b0;
        rptr <= 1'b0;
      end else begin
        if (enq) wptr <= ~wptr;
        if (deq) rptr <= ~rptr;
      end
      if (enq && (count_r != '1)) count_r <= count_r + count_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      cause_mem[wptr] <= cause_enc;
      epc_mem[wptr]   <= epc_i;
      tval_mem[wptr]  <= tval_sel;
    end
  end

  assign cause_o = cause_mem[rptr];
  assign epc_o   = epc_mem[rptr];
  assign tval_o  = tval_mem[rptr];

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule
